// File: rtl/exe_stage_pkg.sv
// Shared widths, ID->EX payload layout, size codes and store-lane helpers for the EX stage.
package exe_stage_pkg;

    localparam int unsigned DS2ES_W   = 243;
    localparam int unsigned ES2MS_W   = 123;
    localparam int unsigned RF_ZIP_W  = 40;
    localparam int unsigned DIV_ITER  = 32;
    localparam int unsigned DIV_CNT_W = $clog2(DIV_ITER);

    // div_op bit positions: {en, signed, rem}
    localparam int unsigned DIV_EN     = 2;
    localparam int unsigned DIV_SIGNED = 1;
    localparam int unsigned DIV_REM    = 0;

    // mem_re size codes, shared by loads and stores
    localparam logic [3:0] MEM_WORD = 4'hf;
    localparam logic [3:0] MEM_HALF = 4'h3;
    localparam logic [3:0] MEM_BYTE = 4'h1;

    // One-hot alu_op bit positions
    localparam int unsigned ALU_ADD  = 0;
    localparam int unsigned ALU_SUB  = 1;
    localparam int unsigned ALU_SLT  = 2;
    localparam int unsigned ALU_SLTU = 3;
    localparam int unsigned ALU_AND  = 4;
    localparam int unsigned ALU_NOR  = 5;
    localparam int unsigned ALU_OR   = 6;
    localparam int unsigned ALU_XOR  = 7;
    localparam int unsigned ALU_SLL  = 8;
    localparam int unsigned ALU_SRL  = 9;
    localparam int unsigned ALU_SRA  = 10;
    localparam int unsigned ALU_LUI  = 11;

    // ID->EX payload, MSB first
    typedef struct packed {
        logic [11:0] alu_op;
        logic [31:0] alu_src1;
        logic [31:0] alu_src2;
        logic [2:0]  div_op;
        logic        mem_we;
        logic        mem_re_s;
        logic [3:0]  mem_re;
        logic [31:0] rkd_value;
        logic        rf_we;
        logic [4:0]  rf_waddr;
        logic        res_from_mem;
        logic        csr_re;
        logic [78:0] csr_zip;
        logic [6:0]  except_zip;
        logic [31:0] pc;
    } ds2es_t;

    typedef enum logic [1:0] {DivIdle, DivBusy, DivDone} div_state_e;

    // Byte write strobes for a store of the given size at the given low address bits
    function automatic logic [3:0] store_strobe(input logic [3:0] size, input logic [1:0] addr);
        logic [3:0] strb;
        case (size)
            MEM_WORD: strb = 4'hf;
            MEM_HALF: strb = 4'b0011 << {addr[1], 1'b0};
            MEM_BYTE: strb = 4'b0001 << addr;
            default:  strb = 4'h0;
        endcase
        return strb;
    endfunction

    // Store data replicated across every lane so the strobes alone pick the bytes
    function automatic logic [31:0] store_wdata(input logic [3:0] size, input logic [31:0] rkd);
        logic [31:0] wd;
        case (size)
            MEM_HALF: wd = {2{rkd[15:0]}};
            MEM_BYTE: wd = {4{rkd[7:0]}};
            default:  wd = rkd;
        endcase
        return wd;
    endfunction

endpackage

// File: rtl/alu.sv
// Combinational integer ALU driven by a one-hot operation vector.
module alu
    import exe_stage_pkg::*;
(
    input  logic [11:0] alu_op,
    input  logic [31:0] alu_src1,
    input  logic [31:0] alu_src2,
    output logic [31:0] alu_result
);

    logic [4:0] shamt;
    logic       lt_s;
    logic       lt_u;

    assign shamt = alu_src2[4:0];
    assign lt_s  = $signed(alu_src1) < $signed(alu_src2);
    assign lt_u  = alu_src1 < alu_src2;

    // AND-OR select across all operations; alu_op is one-hot
    always_comb begin
        alu_result = ({32{alu_op[ALU_ADD]}}  & (alu_src1 + alu_src2))
                   | ({32{alu_op[ALU_SUB]}}  & (alu_src1 - alu_src2))
                   | ({32{alu_op[ALU_SLT]}}  & {31'd0, lt_s})
                   | ({32{alu_op[ALU_SLTU]}} & {31'd0, lt_u})
                   | ({32{alu_op[ALU_AND]}}  & (alu_src1 & alu_src2))
                   | ({32{alu_op[ALU_NOR]}}  & ~(alu_src1 | alu_src2))
                   | ({32{alu_op[ALU_OR]}}   & (alu_src1 | alu_src2))
                   | ({32{alu_op[ALU_XOR]}}  & (alu_src1 ^ alu_src2))
                   | ({32{alu_op[ALU_SLL]}}  & (alu_src1 << shamt))
                   | ({32{alu_op[ALU_SRL]}}  & (alu_src1 >> shamt))
                   | ({32{alu_op[ALU_SRA]}}  & 32'($signed(alu_src1) >>> shamt))
                   | ({32{alu_op[ALU_LUI]}}  & alu_src2);
    end

endmodule

// File: rtl/div_radix2.sv
// Radix-2 restoring divider: one setup cycle, then one quotient bit per cycle.
module div_radix2
    import exe_stage_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        abort,
    input  logic        ack,
    input  logic        sign,
    input  logic [31:0] src1,
    input  logic [31:0] src2,
    output logic        done,
    output logic [31:0] quot,
    output logic [31:0] rem
);

    div_state_e            state_q, state_d;
    logic [DIV_CNT_W-1:0]  cnt_q, cnt_d;
    logic [31:0]           quo_q, quo_d;
    logic [31:0]           rem_q, rem_d;
    logic [31:0]           dsr_q, dsr_d;
    logic                  s1_q, s1_d;
    logic                  s2_q, s2_d;
    logic                  zero_q, zero_d;

    logic [32:0] shifted;
    logic [33:0] diff;

    // Next state: latch magnitudes on start, shift-subtract while busy, abort wins
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        dsr_d   = dsr_q;
        s1_d    = s1_q;
        s2_d    = s2_q;
        zero_d  = zero_q;
        // quo_q doubles as the dividend shift register; its MSB feeds the partial remainder
        shifted = {rem_q, quo_q[31]};
        diff    = {1'b0, shifted} - {2'b00, dsr_q};

        unique case (state_q)
            DivIdle: begin
                if (start) begin
                    state_d = DivBusy;
                    cnt_d   = '0;
                    rem_d   = '0;
                    s1_d    = sign & src1[31];
                    s2_d    = sign & src2[31];
                    quo_d   = (sign & src1[31]) ? 32'd0 - src1 : src1;
                    dsr_d   = (sign & src2[31]) ? 32'd0 - src2 : src2;
                    zero_d  = (src2 == 32'd0);
                end
            end
            DivBusy: begin
                quo_d = {quo_q[30:0], ~diff[33]};
                rem_d = diff[33] ? shifted[31:0] : diff[31:0];
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == DIV_CNT_W'(DIV_ITER - 1)) begin
                    state_d = DivDone;
                end
            end
            DivDone: begin
                if (ack) begin
                    state_d = DivIdle;
                end
            end
            default: state_d = DivIdle;
        endcase

        if (abort) begin
            state_d = DivIdle;
        end
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= DivIdle;
            cnt_q   <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            dsr_q   <= '0;
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            dsr_q   <= dsr_d;
            s1_q    <= s1_d;
            s2_q    <= s2_d;
            zero_q  <= zero_d;
        end
    end

    // Sign fix-up; a zero divisor reports the raw all-ones quotient, remainder is src1
    always_comb begin
        done = (state_q == DivDone);
        if (zero_q) begin
            quot = 32'hffff_ffff;
        end else begin
            quot = (s1_q ^ s2_q) ? 32'd0 - quo_q : quo_q;
        end
        rem = s1_q ? 32'd0 - rem_q : rem_q;
    end

endmodule

// File: rtl/exe_stage.sv
// EX pipeline stage: ALU, iterative divider, data-SRAM request and EX->MEM handoff.
module exe_stage
    import exe_stage_pkg::*;
(
    input  logic                clk,
    input  logic                resetn,
    output logic                es_allowin,
    input  logic                ds2es_valid,
    input  logic [DS2ES_W-1:0]  ds2es_bus,
    input  logic                ms_allowin,
    output logic                es2ms_valid,
    output logic [ES2MS_W-1:0]  es2ms_bus,
    output logic [RF_ZIP_W-1:0] es_rf_zip,
    output logic                data_sram_en,
    output logic [3:0]          data_sram_we,
    output logic [31:0]         data_sram_addr,
    output logic [31:0]         data_sram_wdata,
    output logic                es_ex,
    input  logic                ms_ex,
    input  logic                ws_ex
);

    ds2es_t      ds_in, ds_q, ds_d;
    logic        es_valid_q, es_valid_d;
    logic        es_ready_go;
    logic        div_en, div_start, div_ack, div_done;
    logic [31:0] div_quot, div_rem;
    logic [31:0] alu_result;
    logic [31:0] es_result;

    assign ds_in = ds2es_t'(ds2es_bus);

    alu u_alu (
        .alu_op     (ds_q.alu_op),
        .alu_src1   (ds_q.alu_src1),
        .alu_src2   (ds_q.alu_src2),
        .alu_result (alu_result)
    );

    div_radix2 u_div (
        .clk   (clk),
        .rst_n (resetn),
        .start (div_start),
        .abort (ws_ex),
        .ack   (div_ack),
        .sign  (ds_q.div_op[DIV_SIGNED]),
        .src1  (ds_q.alu_src1),
        .src2  (ds_q.alu_src2),
        .done  (div_done),
        .quot  (div_quot),
        .rem   (div_rem)
    );

    // Handshake, divider control and result selection
    always_comb begin
        div_en      = ds_q.div_op[DIV_EN];
        es_ready_go = ~div_en | div_done;
        es_allowin  = ~es_valid_q | (es_ready_go & ms_allowin);
        es2ms_valid = es_valid_q & es_ready_go;
        div_start   = es_valid_q & div_en & ~ws_ex;
        div_ack     = es2ms_valid & ms_allowin;
        if (div_en) begin
            es_result = ds_q.div_op[DIV_REM] ? div_rem : div_quot;
        end else begin
            es_result = alu_result;
        end
    end

    // Valid/payload next state; a WB flush empties the stage regardless of handshake
    always_comb begin
        es_valid_d = es_valid_q;
        ds_d       = ds_q;
        if (ws_ex) begin
            es_valid_d = 1'b0;
        end else if (es_allowin) begin
            es_valid_d = ds2es_valid;
        end
        if (ds2es_valid & es_allowin) begin
            ds_d = ds_in;
        end
    end

    // Stage registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            es_valid_q <= 1'b0;
            ds_q       <= '0;
        end else begin
            es_valid_q <= es_valid_d;
            ds_q       <= ds_d;
        end
    end

    // SRAM request stays up while stalled so MEM samples the final read; stores are killed
    // by any exception in EX or downstream
    always_comb begin
        es_ex           = es_valid_q & (|ds_q.except_zip);
        data_sram_en    = es_valid_q & (ds_q.mem_we | ds_q.res_from_mem);
        data_sram_addr  = alu_result;
        data_sram_wdata = store_wdata(ds_q.mem_re, ds_q.rkd_value);
        if (ds_q.mem_we & es_valid_q & ~es_ex & ~ms_ex & ~ws_ex) begin
            data_sram_we = store_strobe(ds_q.mem_re, alu_result[1:0]);
        end else begin
            data_sram_we = 4'h0;
        end
    end

    // Downstream buses
    always_comb begin
        es2ms_bus = {ds_q.mem_re_s, ds_q.mem_re, ds_q.csr_zip, ds_q.except_zip, ds_q.pc};
        es_rf_zip = {ds_q.csr_re & es_valid_q, ds_q.res_from_mem, ds_q.rf_we & es_valid_q,
                     ds_q.rf_waddr, es_result};
    end

endmodule

// File: tb/tb_exe_stage.sv
// Directed self-checking bench for exe_stage.
module tb_exe_stage;

    localparam logic [11:0] OP_ADD  = 12'h001;
    localparam logic [11:0] OP_SUB  = 12'h002;
    localparam logic [11:0] OP_SLTU = 12'h008;
    localparam logic [11:0] OP_SLL  = 12'h100;

    logic         clk;
    logic         resetn;
    logic         es_allowin;
    logic         ds2es_valid;
    logic [242:0] ds2es_bus;
    logic         ms_allowin;
    logic         es2ms_valid;
    logic [122:0] es2ms_bus;
    logic [39:0]  es_rf_zip;
    logic         data_sram_en;
    logic [3:0]   data_sram_we;
    logic [31:0]  data_sram_addr;
    logic [31:0]  data_sram_wdata;
    logic         es_ex;
    logic         ms_ex;
    logic         ws_ex;

    int checks = 0;
    int errors = 0;

    exe_stage dut (
        .clk             (clk),
        .resetn          (resetn),
        .es_allowin      (es_allowin),
        .ds2es_valid     (ds2es_valid),
        .ds2es_bus       (ds2es_bus),
        .ms_allowin      (ms_allowin),
        .es2ms_valid     (es2ms_valid),
        .es2ms_bus       (es2ms_bus),
        .es_rf_zip       (es_rf_zip),
        .data_sram_en    (data_sram_en),
        .data_sram_we    (data_sram_we),
        .data_sram_addr  (data_sram_addr),
        .data_sram_wdata (data_sram_wdata),
        .es_ex           (es_ex),
        .ms_ex           (ms_ex),
        .ws_ex           (ws_ex)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Build an ID->EX payload in field order
    function automatic logic [242:0] mk(input logic [11:0] op, input logic [31:0] s1,
                                        input logic [31:0] s2, input logic [2:0] dv,
                                        input logic we, input logic [3:0] re,
                                        input logic [31:0] rkd, input logic rfwe,
                                        input logic [4:0] wa, input logic rfm,
                                        input logic [6:0] exc, input logic [31:0] pc);
        return {op, s1, s2, dv, we, 1'b0, re, rkd, rfwe, wa, rfm, 1'b0, 79'h0, exc, pc};
    endfunction

    // Called at a negedge; payload is taken at the next posedge, returns at the following negedge
    task automatic issue(input logic [242:0] bus);
        ds2es_bus   = bus;
        ds2es_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        ds2es_valid = 1'b0;
    endtask

    task automatic run_div(input string tag, input logic [2:0] dv, input logic [31:0] s1,
                           input logic [31:0] s2, input logic [31:0] exp);
        int lo;
        issue(mk(12'h0, s1, s2, dv, 1'b0, 4'h0, 32'h0, 1'b1, 5'd4, 1'b0, 7'h0, 32'h100));
        lo = 0;
        while (es2ms_valid !== 1'b1 && lo < 40) begin
            lo++;
            @(negedge clk);
        end
        chk({tag, "_lat"}, 32'(lo), 32'd33);
        chk({tag, "_res"}, es_rf_zip[31:0], exp);
        chk({tag, "_ex"}, {31'd0, es_ex}, 32'd0);
    endtask

    initial begin
        resetn      = 1'b0;
        ds2es_valid = 1'b0;
        ds2es_bus   = '0;
        ms_allowin  = 1'b1;
        ms_ex       = 1'b0;
        ws_ex       = 1'b0;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        chk("rst_es2ms_valid", {31'd0, es2ms_valid}, 32'd0);
        chk("rst_allowin", {31'd0, es_allowin}, 32'd1);
        chk("rst_sram_en", {31'd0, data_sram_en}, 32'd0);
        chk("rst_sram_we", {28'd0, data_sram_we}, 32'd0);
        chk("rst_es_ex", {31'd0, es_ex}, 32'd0);
        resetn = 1'b1;
        @(negedge clk);

        // ALU, single-cycle latency
        issue(mk(OP_ADD, 32'd5, 32'd7, 3'b000, 1'b0, 4'h0, 32'h0, 1'b1, 5'd3, 1'b0, 7'h0,
                 32'h1c000040));
        chk("add_valid", {31'd0, es2ms_valid}, 32'd1);
        chk("add_res", es_rf_zip[31:0], 32'd12);
        chk("add_zip_hi", {24'd0, es_rf_zip[39:32]}, 32'h23);
        chk("add_pc", es2ms_bus[31:0], 32'h1c000040);
        chk("add_sram_en", {31'd0, data_sram_en}, 32'd0);
        issue(mk(OP_SUB, 32'd3, 32'd5, 3'b000, 1'b0, 4'h0, 32'h0, 1'b1, 5'd3, 1'b0, 7'h0, 32'h0));
        chk("sub_res", es_rf_zip[31:0], 32'hfffffffe);
        issue(mk(OP_SLTU, 32'd3, 32'hfffffff0, 3'b000, 1'b0, 4'h0, 32'h0, 1'b1, 5'd3, 1'b0,
                 7'h0, 32'h0));
        chk("sltu_res", es_rf_zip[31:0], 32'd1);
        issue(mk(OP_SLL, 32'd1, 32'd31, 3'b000, 1'b0, 4'h0, 32'h0, 1'b1, 5'd3, 1'b0, 7'h0, 32'h0));
        chk("sll_res", es_rf_zip[31:0], 32'h80000000);

        // Divides, issued back to back
        run_div("div_w", 3'b110, 32'hfffffff9, 32'd2, 32'hfffffffd);
        run_div("mod_w", 3'b111, 32'hfffffff9, 32'd2, 32'hffffffff);
        run_div("divu_z", 3'b100, 32'd9, 32'd0, 32'hffffffff);
        run_div("modu_z", 3'b101, 32'd9, 32'd0, 32'd9);
        run_div("div_ovf", 3'b110, 32'h80000000, 32'hffffffff, 32'h80000000);
        run_div("modu", 3'b101, 32'd100, 32'd7, 32'd2);

        // Stores
        issue(mk(OP_ADD, 32'h1000, 32'd3, 3'b000, 1'b1, 4'h1, 32'h11223344, 1'b0, 5'd0, 1'b0,
                 7'h0, 32'h0));
        chk("stb_we", {28'd0, data_sram_we}, 32'h8);
        chk("stb_wdata", data_sram_wdata, 32'h44444444);
        chk("stb_en", {31'd0, data_sram_en}, 32'd1);
        chk("stb_addr", data_sram_addr, 32'h1003);
        ms_ex = 1'b1;
        #1;
        chk("stb_msex_we", {28'd0, data_sram_we}, 32'h0);
        chk("stb_msex_en", {31'd0, data_sram_en}, 32'd1);
        ms_ex = 1'b0;
        issue(mk(OP_ADD, 32'h1000, 32'd2, 3'b000, 1'b1, 4'h3, 32'h11223344, 1'b0, 5'd0, 1'b0,
                 7'h0, 32'h0));
        chk("sth_we", {28'd0, data_sram_we}, 32'hc);
        chk("sth_wdata", data_sram_wdata, 32'h33443344);
        issue(mk(OP_ADD, 32'h1000, 32'd0, 3'b000, 1'b1, 4'hf, 32'h11223344, 1'b0, 5'd0, 1'b0,
                 7'h0, 32'h0));
        chk("stw_we", {28'd0, data_sram_we}, 32'hf);
        chk("stw_wdata", data_sram_wdata, 32'h11223344);
        issue(mk(OP_ADD, 32'h1000, 32'd0, 3'b000, 1'b1, 4'hf, 32'h11223344, 1'b0, 5'd0, 1'b0,
                 7'h05, 32'h0));
        chk("exc_es_ex", {31'd0, es_ex}, 32'd1);
        chk("exc_we", {28'd0, data_sram_we}, 32'h0);
        chk("exc_bus", {25'd0, es2ms_bus[38:32]}, 32'h05);

        // Flush during a busy divide, then a fresh divide
        issue(mk(12'h0, 32'd100, 32'd7, 3'b100, 1'b0, 4'h0, 32'h0, 1'b1, 5'd4, 1'b0, 7'h0,
                 32'h0));
        repeat (5) @(negedge clk);
        ws_ex = 1'b1;
        @(posedge clk);
        @(negedge clk);
        ws_ex = 1'b0;
        chk("flush_valid", {31'd0, es2ms_valid}, 32'd0);
        chk("flush_allowin", {31'd0, es_allowin}, 32'd1);
        chk("flush_rfwe", {31'd0, es_rf_zip[37]}, 32'd0);
        run_div("divu_post", 3'b100, 32'd100, 32'd7, 32'd14);

        // Load held by a MEM stall
        @(posedge clk);
        @(negedge clk);
        ms_allowin = 1'b0;
        issue(mk(OP_ADD, 32'h2000, 32'd4, 3'b000, 1'b0, 4'hf, 32'h0, 1'b1, 5'd6, 1'b1, 7'h0,
                 32'h0));
        for (int i = 0; i < 3; i++) begin
            chk("ldw_stall_en", {31'd0, data_sram_en}, 32'd1);
            chk("ldw_stall_addr", data_sram_addr, 32'h2004);
            chk("ldw_stall_allowin", {31'd0, es_allowin}, 32'd0);
            chk("ldw_stall_rfm", {31'd0, es_rf_zip[38]}, 32'd1);
            @(negedge clk);
        end
        ms_allowin = 1'b1;
        #1;
        chk("ldw_release_allowin", {31'd0, es_allowin}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        chk("ldw_after_valid", {31'd0, es2ms_valid}, 32'd0);
        chk("ldw_after_en", {31'd0, data_sram_en}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
